mdu_iter: RTL
=============

// Module: mdu_iter
// PURPOSE
//   Iterative multiply/divide unit owning the HI/LO register pair. It is the sequential counterpart
//   of the combinational ALU: the decoder issues MULT/MULTU/DIV/DIVU/MTHI/MTLO here, and
//   MFHI/MFLO read HI/LO directly. Radix-2 shift-add multiply and restoring divide, one bit per clock.
//   Sits in EX beside the ALU; the pipeline stalls on busy.
// PARAMETERS
//   WIDTH   32   operand/HI/LO width; only 32 is verified
// PORTS
//   clk     in   1      rising-edge clock
//   rstn    in   1      asynchronous active-low reset
//   start   in   1      issue strobe, sampled on clk edge
//   op      in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 NOP
//   A       in   WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
//   B       in   WIDTH  rt operand (multiplier / divisor)
//   flush   in   1      synchronous cancel of an in-flight operation
//   busy    out  1      1 while iterating (state CALC)
//   done    out  1      one-cycle pulse: HI/LO hold the new result
//   HI      out  WIDTH  HI register (product high / remainder)
//   LO      out  WIDTH  LO register (product low / quotient)
// BEHAVIOUR
//   Reset (rstn=0, async): state IDLE, cnt=0, busy=0, done=0, HI=0, LO=0, internal regs cleared.
//   States: IDLE, CALC, DONE. busy = (state==CALC); done = (state==DONE).
//   IDLE/DONE + start + op in {0..3}: latch operands, cnt<=0, -> CALC.
//     Signed ops: latch magnitudes |A|,|B| and result sign flags (mul: sA^sB; quot: sA^sB; rem: sA).
//   IDLE/DONE + start + op 4/5: HI<=A (MTHI) or LO<=A (MTLO) on that edge; stay/return IDLE; no done.
//   IDLE/DONE + start + op 6/7, or no start: DONE->IDLE, IDLE stays.
//   CALC: one iteration per edge, cnt++. At the edge where cnt==31 the final iteration completes,
//     sign correction applies, HI/LO are written, -> DONE. Latency: start at edge k -> HI/LO
//     updated at edge k+32, done=1 for the cycle following edge k+32, busy=1 for cycles k+1..k+32.
//   start while busy: ignored (no restart, operands not resampled).
//   flush while busy: -> IDLE next edge, HI/LO unchanged, no done. flush has priority over the
//     final-iteration write. flush with start in IDLE/DONE: flush wins, start ignored.
//   Multiply: 64-bit product, HI=prod[63:32], LO=prod[31:0]; signed result = two's complement of
//     the unsigned product when sign flag set (64-bit negate, wraps naturally).
//   Divide: truncate toward zero; quotient sign = sA^sB, remainder sign = dividend sign.
//     Divisor 0 (signed or unsigned): still 32 cycles; LO=32'hFFFF_FFFF, HI=A (original dividend).
//     0x8000_0000 / -1 (DIV): LO=32'h8000_0000, HI=0 (natural wrap, no trap).
//   Reset mid-operation: immediate abort to reset values; no done pulse.
//   HI/LO never change except at: result write, MTHI/MTLO, reset.
// CONFIGURATION
//   MDU_DIV_EN defined: divider datapath built; ops 2/3 behave as above.
//   MDU_DIV_EN undefined: no divider logic; ops 2/3 are treated as NOP (no busy, no done,
//     HI/LO unchanged). Multiply, MTHI/MTLO unaffected.
// TESTING
//   MULT A=7, B=-3 -> busy 32 cycles, done pulse, HI=FFFFFFFF LO=FFFFFFEB.
//   MULTU A=B=FFFFFFFF -> HI=FFFFFFFE LO=00000001; MULT same operands -> HI=0 LO=1.
//   DIV A=-7, B=2 -> LO=FFFFFFFD HI=FFFFFFFF; DIVU A=100, B=0 -> LO=FFFFFFFF HI=00000064.
//   DIV A=80000000, B=FFFFFFFF -> LO=80000000 HI=0; without MDU_DIV_EN, DIV -> busy stays 0.
//   MULT issued, start+MTLO at cycle 5 ignored, flush at cycle 10 -> IDLE, HI/LO unchanged, no done.
//   MTHI A=1234 -> HI=1234 next edge, done=0; rstn low mid-DIVU -> HI=LO=0, busy=0 asynchronously.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide, one bit per clock.
// Optional divider datapath is built only when the MDU_DIV_EN macro is defined.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic sgn_op);
    return (sgn_op && v[WIDTH-1]) ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg_wide(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;    // product high half / partial remainder
  logic [WIDTH-1:0] mq_q, mq_d;      // multiplier / dividend-quotient shift register
  logic [WIDTH-1:0] opnd_q, opnd_d;  // multiplicand / divisor magnitude
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;

  // Multiply step: conditional add, then shift {acc,mq} right by one.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_acc, mul_mq;
  logic [2*WIDTH-1:0] prod;
  assign mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_acc = mul_sum[WIDTH:1];
  assign mul_mq  = {mul_sum[0], mq_q[WIDTH-1:1]};
  assign prod    = {mul_acc, mul_mq};

`ifdef MDU_DIV_EN
  logic             is_div_q, is_div_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
  logic [WIDTH-1:0] aorig_q, aorig_d;
  // Restoring step: the shifted remainder is below twice the divisor, so bit WIDTH is the borrow.
  logic [WIDTH:0]   div_sh, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_acc, div_mq;
  assign div_sh   = {acc_q, mq_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign div_ok   = ~div_diff[WIDTH];
  assign div_acc  = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_mq   = {mq_q[WIDTH-2:0], div_ok};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_DIV_EN
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    aorig_d   = aorig_q;
`endif
    case (state_q)
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
`ifdef MDU_DIV_EN
          if (is_div_q) begin
            acc_d = div_acc;
            mq_d  = div_mq;
            if (cnt_q == CNT_LAST) begin
              state_d = S_DONE;
              lo_d    = dz_q ? '1 : cneg(div_mq, neg_q);
              hi_d    = dz_q ? aorig_q : cneg(div_acc, neg_rem_q);
            end
          end else begin
`else
          begin
`endif
            acc_d = mul_acc;
            mq_d  = mul_mq;
            if (cnt_q == CNT_LAST) begin
              state_d      = S_DONE;
              {hi_d, lo_d} = cneg_wide(prod, neg_q);
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start && !flush) begin
          case (op)
            3'd0, 3'd1: begin
              state_d = S_CALC;
              cnt_d   = '0;
              acc_d   = '0;
              mq_d    = mag(B, op == 3'd0);
              opnd_d  = mag(A, op == 3'd0);
              neg_d   = (op == 3'd0) && (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef MDU_DIV_EN
              is_div_d = 1'b0;
`endif
            end
`ifdef MDU_DIV_EN
            3'd2, 3'd3: begin
              state_d   = S_CALC;
              cnt_d     = '0;
              acc_d     = '0;
              mq_d      = mag(A, op == 3'd2);
              opnd_d    = mag(B, op == 3'd2);
              neg_d     = (op == 3'd2) && (A[WIDTH-1] ^ B[WIDTH-1]);
              neg_rem_d = (op == 3'd2) && A[WIDTH-1];
              dz_d      = (B == '0);
              aorig_d   = A;
              is_div_d  = 1'b1;
            end
`endif
            3'd4:    hi_d = A;
            3'd5:    lo_d = A;
            default: ;
          endcase
        end
      end
    endcase
    busy_d = (state_d == S_CALC);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MDU_DIV_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      aorig_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MDU_DIV_EN
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      aorig_q   <= aorig_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
